// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset core: sequences fetch/decode/execute/
// memory/write-back and drives datapath mux selects and enables from the current state.
module mc_ctrl #(
    parameter logic [1:0] EXT_LOGIC  = 2'b00,
    parameter logic [1:0] EXT_ARITH  = 2'b01,
    parameter logic [1:0] EXT_HIGH16 = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_addr_sel,
    output logic       rf_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWR  = 4'd6,
        S_MEMWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_XOR   = 3'd5;
    localparam logic [2:0] ALU_SLT   = 3'd6;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    state_t state_q, state_d;

    logic op_r, op_addi, op_addiu, op_slti, op_andi, op_ori, op_xori, op_lui;
    logic op_lw, op_sw, op_beq, op_bne, op_j, op_jal, op_ialu;

    assign op_r     = (opcode == 6'b000000);
    assign op_addi  = (opcode == 6'b001000);
    assign op_addiu = (opcode == 6'b001001);
    assign op_slti  = (opcode == 6'b001010);
    assign op_andi  = (opcode == 6'b001100);
    assign op_ori   = (opcode == 6'b001101);
    assign op_xori  = (opcode == 6'b001110);
    assign op_lui   = (opcode == 6'b001111);
    assign op_lw    = (opcode == 6'b100011);
    assign op_sw    = (opcode == 6'b101011);
    assign op_beq   = (opcode == 6'b000100);
    assign op_bne   = (opcode == 6'b000101);
    assign op_j     = (opcode == 6'b000010);
    assign op_jal   = (opcode == 6'b000011);
    assign op_ialu  = op_addi | op_addiu | op_slti | op_andi | op_ori | op_xori | op_lui;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d      = S_FETCH;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        rf_write     = 1'b0;
        reg_dst      = 2'b00;
        wd_sel       = 2'b00;
        alu_srca     = 1'b0;
        alu_srcb     = 2'b00;
        alu_op       = ALU_ADD;
        ext_op       = EXT_LOGIC;
        illegal      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                alu_srcb = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut for BRANCH to use
                alu_srcb = 2'b11;
                ext_op   = EXT_ARITH;
                if (op_r || op_ialu)       state_d = S_EXEC;
                else if (op_lw || op_sw)   state_d = S_MEMADR;
                else if (op_beq || op_bne) state_d = S_BRANCH;
                else if (op_j || op_jal)   state_d = S_JUMP;
                else                       illegal = 1'b1;
            end
            S_EXEC: begin
                alu_srca = 1'b1;
                state_d  = S_ALUWB;
                if (op_r) begin
                    alu_op = ALU_FUNCT;
                end else begin
                    alu_srcb = 2'b10;
                    if (op_addi || op_addiu) begin alu_op = ALU_ADD;   ext_op = EXT_ARITH;  end
                    else if (op_slti)        begin alu_op = ALU_SLT;   ext_op = EXT_ARITH;  end
                    else if (op_andi)        begin alu_op = ALU_AND;   ext_op = EXT_LOGIC;  end
                    else if (op_ori)         begin alu_op = ALU_OR;    ext_op = EXT_LOGIC;  end
                    else if (op_xori)        begin alu_op = ALU_XOR;   ext_op = EXT_LOGIC;  end
                    else if (op_lui)         begin alu_op = ALU_PASSB; ext_op = EXT_HIGH16; end
                end
            end
            S_ALUWB: begin
                rf_write = 1'b1;
                reg_dst  = op_r ? 2'b01 : 2'b00;
            end
            S_MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                ext_op   = EXT_ARITH;
                state_d  = op_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read     = 1'b1;
                mem_addr_sel = 1'b1;
                state_d      = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                mem_write    = 1'b1;
                mem_addr_sel = 1'b1;
                state_d      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_MEMWB: begin
                rf_write = 1'b1;
                wd_sel   = 2'b01;
            end
            S_BRANCH: begin
                alu_srca = 1'b1;
                alu_op   = ALU_SUB;
                ext_op   = EXT_ARITH;
                pc_src   = 2'b01;
                pc_write = (op_beq & zero) | (op_bne & ~zero);
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                if (op_jal) begin
                    rf_write = 1'b1;
                    reg_dst  = 2'b10;
                    wd_sel   = 2'b10;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle and
// compares state plus the full control vector against hand-written expectations.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, mem_addr_sel, rf_write;
    logic       alu_srca, illegal;
    logic [1:0] pc_src, reg_dst, wd_sel, alu_srcb, ext_op;
    logic [2:0] alu_op;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .rf_write(rf_write),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_op(alu_op), .ext_op(ext_op), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: pc_write pc_src ir_write mem_read mem_write mem_addr_sel rf_write
    //              reg_dst wd_sel alu_srca alu_srcb alu_op ext_op illegal
    function automatic logic [20:0] ov(input int pcw, pcs, irw, mr, mw, mas, rfw,
                                       rd, wd, sa, sb, aop, eop, ill);
        logic [31:0] a, b, c, d, e, f, g, h, i, j, k, l, m, n;
        a = pcw; b = pcs; c = irw; d = mr; e = mw; f = mas; g = rfw;
        h = rd;  i = wd;  j = sa;  k = sb; l = aop; m = eop; n = ill;
        return {a[0], b[1:0], c[0], d[0], e[0], f[0], g[0], h[1:0], i[1:0],
                j[0], k[1:0], l[2:0], m[1:0], n[0]};
    endfunction

    function automatic logic [20:0] outs();
        return {pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_sel, rf_write,
                reg_dst, wd_sel, alu_srca, alu_srcb, alu_op, ext_op, illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input int st, input logic [20:0] e);
        logic [31:0] s;
        s = st;
        chk({tag, "_state"}, {28'b0, state}, s);
        chk({tag, "_ctl"}, {11'b0, outs()}, {11'b0, e});
    endtask

    // Check the current cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input int st, input logic [20:0] e);
        #1;
        look(tag, st, e);
        @(posedge clk);
        #1;
    endtask

    logic [20:0] f_rdy, f_wait, dec, dec_ill, wb_i, wb_r, memadr, memrd, memwr, memwb;
    logic [20:0] br_t, br_n, jmp_jal, jmp_j;

    initial begin
        f_rdy   = ov(1,0,1,1,0,0,0, 0,0,0,1,0,0,0);
        f_wait  = ov(0,0,0,1,0,0,0, 0,0,0,1,0,0,0);
        dec     = ov(0,0,0,0,0,0,0, 0,0,0,3,0,1,0);
        dec_ill = ov(0,0,0,0,0,0,0, 0,0,0,3,0,1,1);
        wb_i    = ov(0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
        wb_r    = ov(0,0,0,0,0,0,1, 1,0,0,0,0,0,0);
        memadr  = ov(0,0,0,0,0,0,0, 0,0,1,2,0,1,0);
        memrd   = ov(0,0,0,1,0,1,0, 0,0,0,0,0,0,0);
        memwr   = ov(0,0,0,0,1,1,0, 0,0,0,0,0,0,0);
        memwb   = ov(0,0,0,0,0,0,1, 0,1,0,0,0,0,0);
        br_t    = ov(1,1,0,0,0,0,0, 0,0,1,0,1,1,0);
        br_n    = ov(0,1,0,0,0,0,0, 0,0,1,0,1,1,0);
        jmp_jal = ov(1,2,0,0,0,0,1, 2,2,0,0,0,0,0);
        jmp_j   = ov(1,2,0,0,0,0,0, 0,0,0,0,0,0,0);

        rst = 1'b1; opcode = 6'b001101; zero = 1'b0; mem_ready = 1'b0;
        #2 rst = 1'b0;
        for (int n = 0; n < 3; n++) cyc("rst", 0, f_wait);

        // ori
        rst = 1'b1; mem_ready = 1'b1;
        cyc("ori_f", 0, f_rdy);
        cyc("ori_d", 1, dec);
        cyc("ori_x", 2, ov(0,0,0,0,0,0,0, 0,0,1,2,4,0,0));
        cyc("ori_wb", 3, wb_i);

        opcode = 6'b001111;
        cyc("lui_f", 0, f_rdy);
        cyc("lui_d", 1, dec);
        cyc("lui_x", 2, ov(0,0,0,0,0,0,0, 0,0,1,2,7,2,0));
        cyc("lui_wb", 3, wb_i);

        opcode = 6'b001000;
        cyc("addi_f", 0, f_rdy);
        cyc("addi_d", 1, dec);
        cyc("addi_x", 2, ov(0,0,0,0,0,0,0, 0,0,1,2,0,1,0));
        cyc("addi_wb", 3, wb_i);

        opcode = 6'b000000;
        cyc("r_f", 0, f_rdy);
        cyc("r_d", 1, dec);
        cyc("r_x", 2, ov(0,0,0,0,0,0,0, 0,0,1,0,2,0,0));
        cyc("r_wb", 3, wb_r);

        // lw with two FETCH waits and three MEMRD waits: 10 cycles
        opcode = 6'b100011; mem_ready = 1'b0;
        cyc("lw_fw0", 0, f_wait);
        cyc("lw_fw1", 0, f_wait);
        mem_ready = 1'b1;
        cyc("lw_f", 0, f_rdy);
        cyc("lw_d", 1, dec);
        cyc("lw_ma", 4, memadr);
        mem_ready = 1'b0;
        for (int n = 0; n < 3; n++) cyc("lw_rdw", 5, memrd);
        mem_ready = 1'b1;
        cyc("lw_rd", 5, memrd);
        cyc("lw_wb", 7, memwb);

        opcode = 6'b101011;
        cyc("sw_f", 0, f_rdy);
        cyc("sw_d", 1, dec);
        cyc("sw_ma", 4, memadr);
        cyc("sw_wr", 6, memwr);

        opcode = 6'b000100; zero = 1'b1;
        cyc("beq1_f", 0, f_rdy);
        cyc("beq1_d", 1, dec);
        cyc("beq1_br", 8, br_t);
        zero = 1'b0;
        cyc("beq0_f", 0, f_rdy);
        cyc("beq0_d", 1, dec);
        cyc("beq0_br", 8, br_n);
        opcode = 6'b000101;
        cyc("bne0_f", 0, f_rdy);
        cyc("bne0_d", 1, dec);
        cyc("bne0_br", 8, br_t);
        zero = 1'b1;
        cyc("bne1_f", 0, f_rdy);
        cyc("bne1_d", 1, dec);
        cyc("bne1_br", 8, br_n);

        opcode = 6'b000011;
        cyc("jal_f", 0, f_rdy);
        cyc("jal_d", 1, dec);
        cyc("jal_jp", 9, jmp_jal);
        opcode = 6'b000010;
        cyc("j_f", 0, f_rdy);
        cyc("j_d", 1, dec);
        cyc("j_jp", 9, jmp_j);

        opcode = 6'b111111;
        cyc("ill_f", 0, f_rdy);
        cyc("ill_d", 1, dec_ill);

        // sw stalled in MEMWR, then async reset mid-cycle
        opcode = 6'b101011;
        cyc("swr_f", 0, f_rdy);
        cyc("swr_d", 1, dec);
        mem_ready = 1'b0;
        cyc("swr_ma", 4, memadr);
        cyc("swr_w0", 6, memwr);
        #1;
        look("swr_w1", 6, memwr);
        rst = 1'b0;
        #1;
        look("swr_rst", 0, f_wait);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("post_rst", 0, f_wait);
        #1;
        look("post_rst_hold", 0, f_wait);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS-subset core.
- Sequences instruction fetch, decode, execute, memory and write-back over several cycles, so the ALU, memory port and immediate extender are reused across steps.
- Drives ext_op to the immediate extender on every cycle.
- Sits between the IR and the datapath muxes/enables.
- Stalls on a memory ready handshake.

Parameters:
- EXT_LOGIC, 2'b00, zero-extend code for ext_op.
- EXT_ARITH, 2'b01, sign-extend code for ext_op.
- EXT_HIGH16, 2'b10, imm<<16 code for ext_op.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr_sel  out  1  memory address: 0 = PC, 1 = ALUOut.
- rf_write  out  1  register file write enable.
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = r31.
- wd_sel  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- alu_srca  out  1  ALU operand A: 0 = PC, 1 = rs.
- alu_srcb  out  2  ALU operand B: 00 = rt, 01 = const 4, 10 = ext, 11 = ext<<2.
- alu_op  out  3  0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 PASSB.
- ext_op  out  2  extender mode.
- illegal  out  1  one-cycle pulse on an undecoded opcode.
- state  out  4  current state, for debug.

Behaviour:
- Single state register, 4 bits. On rst low the state is FETCH immediately (asynchronous), including mid-instruction; a pending memory access is abandoned.
- All outputs are combinational from state, opcode and zero. Any output not listed for a state is 0.
- Reset output values are the FETCH values, all taken with mem_ready=0:
  - mem_read=1, mem_addr_sel=0, alu_srca=0, alu_srcb=01, alu_op=ADD, ext_op=EXT_LOGIC.
  - Everything else 0.
- Supported opcodes: R-type 000000, addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- FETCH (0):
  - Outputs: mem_read=1, alu computes PC+4.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
  - Otherwise hold in FETCH with no enables asserted.
- DECODE (1):
  - Outputs: alu_srca=0, alu_srcb=11, alu_op=ADD, ext_op=EXT_ARITH (branch target into ALUOut).
  - Next state by opcode:
    - R-type and I-ALU ops -> EXEC.
    - lw/sw -> MEMADR.
    - beq/bne -> BRANCH.
    - j/jal -> JUMP.
    - Any other opcode -> FETCH with illegal=1 this cycle only.
- EXEC (2):
  - alu_srca=1.
  - R-type: alu_srcb=00, alu_op=FUNCT.
  - Immediate ops: alu_srcb=10.
    - addi/addiu: ADD, EXT_ARITH.
    - slti: SLT, EXT_ARITH.
    - andi: AND, EXT_LOGIC.
    - ori: OR, EXT_LOGIC.
    - xori: XOR, EXT_LOGIC.
    - lui: PASSB, EXT_HIGH16.
  - Next state ALUWB.
- ALUWB (3): rf_write=1, wd_sel=00, reg_dst=01 for R-type else 00. Next state FETCH.
- MEMADR (4):
  - alu_srca=1, alu_srcb=10, alu_op=ADD, ext_op=EXT_ARITH.
  - Next state MEMRD for lw, MEMWR for sw.
- MEMRD (5): mem_read=1, mem_addr_sel=1. Hold until mem_ready, then MEMWB.
- MEMWR (6): mem_write=1, mem_addr_sel=1. Hold until mem_ready, then FETCH. mem_write stays high for every wait cycle.
- MEMWB (7): rf_write=1, reg_dst=00, wd_sel=01. Next state FETCH.
- BRANCH (8):
  - alu_srca=1, alu_srcb=00, alu_op=SUB, ext_op=EXT_ARITH, pc_src=01.
  - pc_write = (beq & zero) | (bne & ~zero).
  - Next state FETCH.
- JUMP (9):
  - pc_write=1, pc_src=10.
  - jal only: rf_write=1, reg_dst=10, wd_sel=10.
  - Next state FETCH.
- Unused encodings 10-15: all outputs 0, next state FETCH.
- Cycle counts with mem_ready tied high:
  - R/I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j/jal: 3 cycles.
  - Each wait cycle adds 1.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Test Plan:
1. rst low for 3 cycles, then high with mem_ready=1 and opcode=001101 (ori): state sequence 0,1,2,3,0. In EXEC: ext_op=00, alu_op=4, alu_srcb=10. In ALUWB: rf_write=1, reg_dst=00.
2. opcode=001111 (lui), then opcode=001000 (addi): EXEC ext_op=10/alu_op=7 for lui, then ext_op=01/alu_op=0 for addi. DECODE ext_op=01 in both.
3. lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD: FETCH held 3 cycles with ir_write=0 until ready. mem_read=1 throughout MEMRD. Total 10 cycles; MEMWB wd_sel=01.
4. beq with zero=1, then beq with zero=0, then bne with zero=0: BRANCH pc_write=1, 0, 1 respectively. pc_src=01 in all three.
5. jal: JUMP asserts pc_write=1, pc_src=10, rf_write=1, reg_dst=10, wd_sel=10. Next cycle state=0.
6. opcode=111111: illegal=1 for exactly the DECODE cycle, next state FETCH. Separately, rst asserted during MEMWR: state=0 and mem_write=0 without waiting for a clock edge.
